instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch front end of the 5-stage pipelined RV32I core. It owns the PC, issues one word request at a time to instruction memory over a valid-only request / response handshake, and fills the IF/ID pipeline register. The ID-stage immediate generator, register file and control unit decode the IF/ID register. Load-use stalls from hazard detection and branch/jump redirects from EX are applied here.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-detection hold of PC and IF/ID.
- flush  in  1  EX redirect (taken branch, JAL, JALR).
- redirect_pc  in  32  target PC, sampled when flush=1.
- imem_req  out  1  single-cycle request strobe; memory always accepts.
- imem_addr  out  32  request address (current PC).
- imem_rvalid  in  1  response strobe, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- if_id_inst  out  32  IF/ID instruction; drives the immediate generator's instruction input.
- if_id_pc  out  32  PC of if_id_inst.
- if_id_valid  out  1  IF/ID holds a real instruction.

## Operation
- The FSM has three states:
  - ISSUE: request in flight this cycle.
  - WAIT: one request outstanding.
  - HOLD: response buffered in the skid register.
- Request outputs:
  - imem_req = (state==ISSUE) & ~flush.
  - imem_addr = pc.
- ISSUE:
  - with req: go to WAIT.
  - with flush: pc<=redirect_pc; stay in ISSUE.
- WAIT, imem_rvalid=1, no drop, no flush:
  - pc<=pc+4.
  - If ~stall: IF/ID<={rdata, pc, 1}; go to ISSUE.
  - If stall: skid<={rdata, pc}; go to HOLD.
- HOLD:
  - ~stall: IF/ID<={skid, 1}; go to ISSUE.
  - stall: everything holds.
- Stale responses:
  - flush in WAIT sets drop=1.
  - The next rvalid with drop=1 is discarded, drop<=0, go to ISSUE.
  - flush and rvalid in the same WAIT cycle: response discarded, drop stays 0, go to ISSUE.
- Flush, in any state, and overriding stall:
  - pc<=redirect_pc.
  - IF/ID<={NOP, 0, 0}.
  - skid cleared.
  - HOLD goes to ISSUE.
- Bubble: when ~stall, ~flush and no instruction is written into IF/ID this cycle, IF/ID<={NOP, 0, 0}.
- Stall: IF/ID, pc and HOLD contents are unchanged. An outstanding WAIT response is still captured into skid.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0. redirect_pc[1:0] is forced to 0.
- NOP = 32'h0000_0013 (addi x0,x0,0).

## Timing
- Reset values, applied at the first rising edge with reset=0:
  - pc=RESET_PC, state=ISSUE, drop=0.
  - if_id_inst=NOP, if_id_pc=0, if_id_valid=0.
  - imem_req is 1 in the first cycle after reset deasserts.
- Reset asserted mid-request: the outstanding response is ignored. After reset, the FSM starts clean in ISSUE; drop is not set.
- Latency: with memory latency L (rvalid L cycles after req), the instruction is in IF/ID at the edge after rvalid. Throughput is one instruction per L+1 cycles.
- All outputs except imem_req are registered. imem_req is combinational on state and flush.
- At most one request is outstanding, and at most one buffered word (skid).

## Structure
- The shared include alongside opcodes.v holds:
  - NOP constant.
  - FSM state encodings (2 bits).
  - PC increment constant 4.
- Natural sub-module: if_id_register. It holds {inst, pc, valid} with load / bubble / hold controls and reset to NOP/0/0.
- PC, skid, drop and the FSM live in the top module.

## Test plan
- Reset then free run, memory L=1, words 0x00500093, 0x00A00113:
  - imem_addr is 0x0 then 0x4.
  - IF/ID shows {0x00500093, pc 0x0, valid 1}, then {0x00A00113, 0x4, 1}.
  - Bubbles (valid 0, inst 0x13) in the cycles between.
- Stall held 3 cycles across rvalid of word at 0x8:
  - Word goes to HOLD; IF/ID is unchanged while stalled.
  - Word appears with pc 0x8 the cycle after stall drops.
  - Next request address is 0xC.
- Flush with redirect_pc=0x40 while in WAIT (L=3):
  - IF/ID is bubbled.
  - The returning word for the old PC is discarded.
  - Next imem_addr is 0x40.
- Flush and rvalid in the same cycle:
  - Response dropped, drop stays 0.
  - Next request is 0x40; the following response is delivered.
- Flush and stall together while in HOLD:
  - Flush wins: skid cleared, IF/ID bubbled, next request is redirect_pc.
- Reset asserted while WAIT:
  - All outputs return to reset values.
  - A late rvalid arriving during reset is ignored.
  - First post-reset request is to RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID payload type for the RV32I fetch stage.
package instruction_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST      = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC        = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

    // Redirect targets are word aligned; the low two bits are discarded.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: bubble has priority over load, otherwise holds.
module if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid
);

    if_id_t r_ifid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ifid.inst  <= NOP_INST;
            r_ifid.pc    <= '0;
            r_ifid.valid <= 1'b0;
        end else if (i_bubble) begin
            r_ifid.inst  <= NOP_INST;
            r_ifid.pc    <= '0;
            r_ifid.valid <= 1'b0;
        end else if (i_load) begin
            r_ifid.inst  <= i_inst;
            r_ifid.pc    <= i_pc;
            r_ifid.valid <= 1'b1;
        end
    end

    assign o_inst  = r_ifid.inst;
    assign o_pc    = r_ifid.pc;
    assign o_valid = r_ifid.valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch front end: owns the PC, runs one outstanding imem request at a time,
// buffers a stalled response in a skid register and feeds the IF/ID register.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_valid
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic [XLEN-1:0] r_skid_inst;
    logic [XLEN-1:0] w_skid_inst_nxt;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] w_skid_pc_nxt;

    logic            w_ifid_load;
    logic            w_ifid_bubble;
    logic [XLEN-1:0] w_ifid_inst;
    logic [XLEN-1:0] w_ifid_pc;

    // State, PC, drop flag and skid buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_ISSUE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

    // Next-state logic; a flush overrides stall and every in-flight decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_nxt      = r_drop;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;
        w_ifid_load     = 1'b0;
        w_ifid_inst     = r_skid_inst;
        w_ifid_pc       = r_skid_pc;

        if (flush) begin
            w_pc_nxt        = align_pc(redirect_pc);
            w_skid_inst_nxt = '0;
            w_skid_pc_nxt   = '0;
            case (r_state)
                ST_WAIT: begin
                    // A response arriving with the flush is simply discarded;
                    // otherwise the still-pending one must be dropped later.
                    if (imem_rvalid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_ISSUE;
            endcase
        end else begin
            case (r_state)
                ST_ISSUE: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = ST_ISSUE;
                        end else begin
                            w_pc_nxt = r_pc + PC_INC;
                            if (stall) begin
                                w_skid_inst_nxt = imem_rdata;
                                w_skid_pc_nxt   = r_pc;
                                w_state_nxt     = ST_HOLD;
                            end else begin
                                w_ifid_load = 1'b1;
                                w_ifid_inst = imem_rdata;
                                w_ifid_pc   = r_pc;
                                w_state_nxt = ST_ISSUE;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_ifid_load = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
                default: w_state_nxt = ST_ISSUE;
            endcase
        end
    end

    assign w_ifid_bubble = flush | (~stall & ~w_ifid_load);

    assign imem_req  = (r_state == ST_ISSUE) & ~flush;
    assign imem_addr = r_pc;

    if_id_register u_if_id (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_ifid_load),
        .i_bubble (w_ifid_bubble),
        .i_inst   (w_ifid_inst),
        .i_pc     (w_ifid_pc),
        .o_inst   (if_id_inst),
        .o_pc     (if_id_pc),
        .o_valid  (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a randomized run,
// compared cycle by cycle against a transaction-level fetch model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory responder state
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = '0;

    // reference model: one outstanding fetch, one buffered word, stale marker
    bit          m_out, m_stale, m_buf, m_valid;
    logic [31:0] m_pc, m_out_pc, m_buf_inst, m_buf_pc, m_inst, m_ipc;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic [97:0] obs_v, exp_v;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[21:2], 12'h0B3} ^ 32'h5A5A_5000;
    endfunction

    function automatic bit rv_now();
        return mem_busy && (mem_cnt == 0);
    endfunction

    task automatic model_reset();
        m_out = 0; m_stale = 0; m_buf = 0;
        m_pc = RST_PC; m_inst = NOP; m_ipc = '0; m_valid = 0;
    endtask

    task automatic model_step(input bit st, input bit fl, input logic [31:0] rpc,
                              input bit rv, input logic [31:0] rd,
                              output bit e_req, output logic [31:0] e_addr);
        bit          dlv;
        logic [31:0] d_inst, d_pc;
        dlv = 0; d_inst = '0; d_pc = '0;
        e_req  = !m_out && !m_buf && !fl;
        e_addr = m_pc;
        if (fl) begin
            m_stale = m_out && !rv;
            if (rv) m_out = 0;
            m_buf = 0;
            m_pc  = rpc & 32'hFFFF_FFFC;
        end else if (e_req) begin
            m_out = 1; m_out_pc = m_pc;
        end else if (m_out && rv) begin
            m_out = 0;
            if (m_stale) m_stale = 0;
            else begin
                m_pc = m_pc + 32'd4;
                if (st) begin m_buf = 1; m_buf_inst = rd; m_buf_pc = m_out_pc; end
                else begin dlv = 1; d_inst = rd; d_pc = m_out_pc; end
            end
        end else if (m_buf && !st) begin
            dlv = 1; d_inst = m_buf_inst; d_pc = m_buf_pc; m_buf = 0;
        end
        if (fl || (!dlv && !st)) begin m_inst = NOP; m_ipc = '0; m_valid = 0; end
        else if (dlv) begin m_inst = d_inst; m_ipc = d_pc; m_valid = 1; end
    endtask

    // One clock: drive inputs, sample request, advance model and memory.
    task automatic step(input bit rst, input bit st, input bit fl, input logic [31:0] rpc);
        bit          rv, e_req;
        logic [31:0] e_addr;
        reset = ~rst; stall = st; flush = fl; redirect_pc = rpc;
        rv = rv_now();
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
        obs_req = imem_req; obs_addr = imem_addr;
        if (rst) begin model_reset(); e_req = 0; e_addr = '0; end
        else model_step(st, fl, rpc, rv, imem_rdata, e_req, e_addr);
        @(posedge clk); #1;
        if (rv) mem_busy = 0;
        if (obs_req && !rst) begin
            mem_busy = 1; mem_addr = obs_addr; mem_cnt = mem_lat - 1;
        end else if (mem_busy) mem_cnt--;
        obs_v = {rst ? 1'b0 : obs_req, rst ? 32'h0 : obs_addr, if_id_inst, if_id_pc, if_id_valid};
        exp_v = {e_req, e_addr, m_inst, m_ipc, m_valid};
        cyc++;
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && (m_out || m_buf); i++) begin
            step(0, 0, 0, '0);
            if (obs_v !== exp_v) begin errors++; $display("FAIL settle cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
        end
        if (m_out || m_buf) begin errors++; $display("FAIL settle timeout: got busy want idle"); end
        checks++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, '0);
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
        end
        if ({if_id_inst, if_id_pc, if_id_valid, imem_req, imem_addr} !== {NOP, 32'h0, 1'b0, 1'b1, RST_PC}) begin
            errors++; $display("FAIL reset_values: got %h %h %b %b %h want 00000013 0 0 1 0",
                               if_id_inst, if_id_pc, if_id_valid, imem_req, imem_addr);
        end
        checks++;
    endtask

    task automatic test_free_run();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0);
            if (obs_v !== exp_v) begin errors++; $display("FAIL free_run cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if ((i == 0 || i == 2) && {obs_req, obs_addr} !== {1'b1, 32'(i * 2)}) begin
                errors++; $display("FAIL free_run_addr i=%0d: got %b %h want 1 %h", i, obs_req, obs_addr, 32'(i * 2));
            end
            if (i == 1 && {if_id_inst, if_id_pc, if_id_valid} !== {32'h0050_0093, 32'h0, 1'b1}) begin
                errors++; $display("FAIL free_run_w0: got %h %h %b", if_id_inst, if_id_pc, if_id_valid);
            end
            if (i == 3 && {if_id_inst, if_id_pc, if_id_valid} !== {32'h00A0_0113, 32'h4, 1'b1}) begin
                errors++; $display("FAIL free_run_w1: got %h %h %b", if_id_inst, if_id_pc, if_id_valid);
            end
            if (i != 0) checks++;
        end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        settle();
        for (int i = 0; i < 6; i++) begin
            step(0, (i >= 1 && i <= 3), 0, '0);
            if (obs_v !== exp_v) begin errors++; $display("FAIL stall cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if (i == 4 && {if_id_inst, if_id_pc, if_id_valid} !== {mem_word(32'h8), 32'h8, 1'b1}) begin
                errors++; $display("FAIL stall_release: got %h %h %b want pc 8 valid 1", if_id_inst, if_id_pc, if_id_valid);
            end
            if (i == 5 && {obs_req, obs_addr} !== {1'b1, 32'hC}) begin
                errors++; $display("FAIL stall_next_addr: got %b %h want 1 0000000c", obs_req, obs_addr);
            end
            if (i >= 4) checks++;
        end
    endtask

    task automatic test_flush_wait();
        mem_lat = 3;
        settle();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, (i == 1), 32'h40);
            if (obs_v !== exp_v) begin errors++; $display("FAIL flush_wait cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if ((i == 1 || i == 3) && if_id_valid !== 1'b0) begin
                errors++; $display("FAIL flush_wait_bubble i=%0d: got valid %b want 0", i, if_id_valid);
            end
            if (i == 4 && {obs_req, obs_addr} !== {1'b1, 32'h40}) begin
                errors++; $display("FAIL flush_wait_addr: got %b %h want 1 00000040", obs_req, obs_addr);
            end
            if (i == 1 || i == 3 || i == 4) checks++;
        end
    endtask

    task automatic test_flush_rvalid();
        bit fl, done;
        int after;
        mem_lat = 2;
        settle();
        done = 0; after = 0;
        for (int i = 0; i < 12; i++) begin
            fl = !done && rv_now();
            step(0, 0, fl, 32'h40);
            if (obs_v !== exp_v) begin errors++; $display("FAIL flush_rvalid cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if (done) after++;
            if (fl) begin
                done = 1;
                if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_rvalid_drop: got valid %b want 0", if_id_valid); end
                checks++;
            end
            if (after == 1 && {obs_req, obs_addr} !== {1'b1, 32'h40}) begin
                errors++; $display("FAIL flush_rvalid_addr: got %b %h want 1 00000040", obs_req, obs_addr);
            end
            if (after == 3 && {if_id_inst, if_id_pc, if_id_valid} !== {mem_word(32'h40), 32'h40, 1'b1}) begin
                errors++; $display("FAIL flush_rvalid_deliver: got %h %h %b want pc 40 valid 1", if_id_inst, if_id_pc, if_id_valid);
            end
            if (after == 1 || after == 3) checks++;
        end
        if (!done) begin errors++; $display("FAIL flush_rvalid_timeout: got no rvalid want one"); end
        checks++;
    endtask

    task automatic test_flush_stall_hold();
        mem_lat = 1;
        settle();
        for (int i = 0; i < 5; i++) begin
            step(0, (i == 1 || i == 2), (i == 2), 32'h80);
            if (obs_v !== exp_v) begin errors++; $display("FAIL flush_hold cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if (i == 2 && {if_id_inst, if_id_valid} !== {NOP, 1'b0}) begin
                errors++; $display("FAIL flush_hold_bubble: got %h %b want 00000013 0", if_id_inst, if_id_valid);
            end
            if (i == 3 && ({obs_req, obs_addr} !== {1'b1, 32'h80} || if_id_valid !== 1'b0)) begin
                errors++; $display("FAIL flush_hold_redirect: got %b %h valid %b want 1 00000080 valid 0", obs_req, obs_addr, if_id_valid);
            end
            if (i == 4 && {if_id_pc, if_id_valid} !== {32'h80, 1'b1}) begin
                errors++; $display("FAIL flush_hold_deliver: got %h %b want 00000080 1", if_id_pc, if_id_valid);
            end
            if (i >= 2) checks++;
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        settle();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, (i == 0), 32'hFFFF_FFFE);
            if (obs_v !== exp_v) begin errors++; $display("FAIL wrap cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if (i == 1 && {obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
                errors++; $display("FAIL wrap_align: got %b %h want 1 fffffffc", obs_req, obs_addr);
            end
            if (i == 3 && {obs_req, obs_addr} !== {1'b1, 32'h0}) begin
                errors++; $display("FAIL wrap_zero: got %b %h want 1 00000000", obs_req, obs_addr);
            end
            if (i == 1 || i == 3) checks++;
        end
    endtask

    task automatic test_reset_wait();
        mem_lat = 3;
        settle();
        for (int i = 0; i < 6; i++) begin
            step((i >= 2 && i <= 4), 0, 0, '0);
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_wait cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
            if (i == 4 && {if_id_inst, if_id_pc, if_id_valid} !== {NOP, 32'h0, 1'b0}) begin
                errors++; $display("FAIL reset_wait_ifid: got %h %h %b want 00000013 0 0", if_id_inst, if_id_pc, if_id_valid);
            end
            if (i == 5 && {obs_req, obs_addr} !== {1'b1, RST_PC}) begin
                errors++; $display("FAIL reset_wait_addr: got %b %h want 1 00000000", obs_req, obs_addr);
            end
            if (i >= 4) checks++;
        end
    endtask

    task automatic test_random();
        bit          st, fl;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            st      = ($urandom_range(0, 9) < 3);
            fl      = ($urandom_range(0, 19) == 0);
            rpc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'($urandom());
            mem_lat = $urandom_range(1, 4);
            step(0, st, fl, rpc);
            if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs_v, exp_v); end
            checks++;
        end
        settle();
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_free_run();
        test_stall();
        test_flush_wait();
        test_flush_rvalid();
        test_flush_stall_hold();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
